mult_div_sequencer: RTL

Iterative multiply/divide controller that replaces the single-cycle combinational multiply/divide path feeding the Lo/Hi register in the pipelined CPU. It accepts one `mult`/`multu`/`div`/`divu` request from the execute stage and runs a 32-step shift-add (multiply) or restoring-subtract (divide) sequence. It delivers the 64-bit {hi, lo} result with a one-cycle write-enable pulse to the Lo/Hi register. It also raises a pipeline stall whenever a new request or an `mfhi`/`mflo` read arrives while a sequence is in flight.

---
 rtl/mips_md_pkg.sv | 21 ++
 rtl/md_iter_step.sv | 58 +++++
 rtl/mult_div_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_md_pkg.sv
// -----------------------------------------------------------------------------
// mips_md_pkg
// Shared constants for the iterative multiply/divide sequencer:
//   - FSM state encoding (IDLE/CALC/FIXUP/DONE)
//   - MD_ITER   : operand width, which is also the iteration count
//   - MD_DBZ_LO : value written to Lo when the divisor is zero
// -----------------------------------------------------------------------------
package mips_md_pkg;

    localparam int MD_ITER = 32;

    localparam logic [31:0] MD_DBZ_LO = 32'hFFFF_FFFF;

    // Plain localparam encoding keeps the state register compatible with
    // older tools and netlist-level debug scripts.
    localparam logic [1:0] MD_ST_IDLE  = 2'd0;
    localparam logic [1:0] MD_ST_CALC  = 2'd1;
    localparam logic [1:0] MD_ST_FIXUP = 2'd2;
    localparam logic [1:0] MD_ST_DONE  = 2'd3;

endpackage : mips_md_pkg

// File: rtl/md_iter_step.sv
// -----------------------------------------------------------------------------
// md_iter_step
// Purely combinational single iteration of the multiply/divide sequence.
// The sequencer keeps one (2*WIDTH+1)-bit accumulator that is shared by
// both operations:
//   multiply: acc = {carry, partial_hi, multiplier/partial_lo}
//             add the multiplicand into the upper part when acc[0] = 1,
//             then shift the whole accumulator right by one.
//   divide  : acc = {0, rem, quot}
//             shift {rem, quot} left by one, trial-subtract the divisor
//             from rem and keep the difference (quot[0] = 1) if it is
//             non-negative.
// Ports:
//   is_mult  in   1 = multiply step, 0 = divide step
//   acc_in   in   accumulator before this step
//   opnd     in   multiplicand (multiply) or divisor (divide) magnitude
//   acc_out  out  accumulator after this step
// -----------------------------------------------------------------------------
module md_iter_step
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic               is_mult,
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0] mul_upper;
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: the carry bit of the upper part is always 0 at the start
        // of a step (the previous shift cleared it), so WIDTH+1 bits of sum
        // never overflow.
        mul_upper = acc_in[2*WIDTH:WIDTH];
        mul_sum   = acc_in[0] ? (mul_upper + {1'b0, opnd}) : mul_upper;

        // Divide: {rem, quot[MSB]} is rem shifted left with the next
        // dividend bit brought in. It is always below 2*divisor, so the
        // top bit of the WIDTH+1 bit difference is a clean borrow flag.
        rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd};

        acc_out = '0;
        if (is_mult) begin
            acc_out = {1'b0, mul_sum, acc_in[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_out = {1'b0, diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {1'b0, rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule : md_iter_step

// File: rtl/mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer
// Iterative multiply/divide controller feeding the Lo/Hi register. Accepts
// one mult/multu/div/divu request, runs WIDTH shift-add or restoring
// shift-subtract steps on operand magnitudes, applies sign correction, and
// delivers {hi, lo} with a one-cycle write-enable pulse.
//
// Timing (start accepted in cycle 0): CALC cycles 1..WIDTH, FIXUP cycle
// WIDTH+1, DONE cycle WIDTH+2 (lhr_wen = 1, p valid). Divide by zero goes
// straight to DONE in cycle 1.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request from execute stage (ignored while busy)
//   is_mult      in   1 = multiply, 0 = divide (sampled with start)
//   is_unsigned  in   1 = unsigned operation (sampled with start)
//   a, b         in   rs / rt operands (sampled with start)
//   lhr_ren      in   mfhi/mflo in execute stage this cycle
//   busy         out  sequence in flight (CALC, FIXUP, DONE)
//   stall        out  hold IF/ID/EX: busy & (start | lhr_ren)
//   lhr_wen      out  one-cycle pulse, Lo/Hi register captures p
//   p            out  result {hi, lo}; changes only on entry to DONE
//   div_by_zero  out  pulses with lhr_wen when the divisor was zero
// -----------------------------------------------------------------------------
module mult_div_sequencer
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_mult,
    input  logic                 is_unsigned,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 lhr_ren,
    output logic                 busy,
    output logic                 stall,
    output logic                 lhr_wen,
    output logic [2*WIDTH-1:0]   p,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,    state_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [2*WIDTH:0]   acc_q,      acc_d;
    logic [WIDTH-1:0]   opnd_q,     opnd_d;
    logic               is_mult_q,  is_mult_d;
    logic               neg_q,      neg_d;      // product / quotient negative
    logic               rem_neg_q,  rem_neg_d;  // remainder negative
    logic               dbz_q,      dbz_d;
    logic [2*WIDTH-1:0] p_q,        p_d;

    // ------------------------------------------------------------------
    // Operand magnitudes and sign fixup terms
    // ------------------------------------------------------------------
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH:0]   step_acc;

    // The most negative value maps to itself under negation, which is the
    // correct unsigned magnitude; this is why 0x80000000 / -1 needs no
    // special case.
    assign a_neg = !is_unsigned && a[WIDTH-1];
    assign b_neg = !is_unsigned && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign prod_raw = acc_q[2*WIDTH-1:0];
    assign prod_fix = neg_q     ? -prod_raw                : prod_raw;
    assign quot_fix = neg_q     ? -acc_q[WIDTH-1:0]        : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]  : acc_q[2*WIDTH-1:WIDTH];

    md_iter_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .is_mult (is_mult_q),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (step_acc)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_mult_d = is_mult_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        p_d       = p_q;

        case (state_q)
            MD_ST_IDLE: begin
                if (start) begin
                    is_mult_d = is_mult;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (is_mult) begin
                        // Multiplier sits in the low half and is consumed LSB first.
                        acc_d  = {1'b0, {WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end else begin
                        // Dividend sits in the quotient half and is shifted out MSB first.
                        acc_d  = {1'b0, {WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end
                    if (!is_mult && (b == '0)) begin
                        // Divide by zero: hi gets the raw dividend, lo all ones.
                        p_d     = {a, WIDTH'(MD_DBZ_LO)};
                        dbz_d   = 1'b1;
                        state_d = MD_ST_DONE;
                    end else begin
                        state_d = MD_ST_CALC;
                    end
                end
            end

            MD_ST_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = MD_ST_FIXUP;
                end
            end

            MD_ST_FIXUP: begin
                // p is loaded here so it is already valid in the DONE cycle.
                if (is_mult_q) begin
                    p_d = prod_fix;
                end else begin
                    p_d = {rem_fix, quot_fix};
                end
                state_d = MD_ST_DONE;
            end

            default: begin  // MD_ST_DONE
                dbz_d   = 1'b0;
                state_d = MD_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset as well, so a discarded
            // sequence leaves no stale accumulator or result behind.
            state_q   <= MD_ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_mult_q <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_mult_q <= is_mult_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            p_q       <= p_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (state_q != MD_ST_IDLE);
    assign stall       = busy && (start || lhr_ren);
    assign lhr_wen     = (state_q == MD_ST_DONE);
    assign div_by_zero = (state_q == MD_ST_DONE) && dbz_q;
    assign p           = p_q;

endmodule : mult_div_sequencer
